step_gen: RTL and testbench

STEP_GEN -- requirements
Module: step_gen

---
 rtl/step_gen.sv | 101 ++++++++++
 tb/tb_step_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/step_gen.sv
// One-hot step sequencer. It runs free or in single cycles, can be stalled with iHOLD,
// and counts completed cycles. State is cleared by an asynchronous active-high reset.
module step_gen #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned STEP_W    = 2,
  parameter int unsigned CYC_W     = 16
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iMODE,
  input  logic                 iGO,
  input  logic                 iHOLD,
  output logic [NUM_STEPS-1:0] oSTEP,
  output logic [STEP_W-1:0]    oPHASE,
  output logic                 oLAST,
  output logic                 oDONE,
  output logic                 oBUSY,
  output logic [CYC_W-1:0]     oCYCLES
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [STEP_W-1:0]    LastPhase = STEP_W'(NUM_STEPS - 1);
  localparam logic [NUM_STEPS-1:0] FirstStep = NUM_STEPS'(1);

  state_e                 state_q, state_d;
  logic [NUM_STEPS-1:0]   step_q, step_d;
  logic [STEP_W-1:0]      phase_q, phase_d;
  logic                   done_q, done_d;
  logic [CYC_W-1:0]       cycles_q, cycles_d;

  // Holds every piece of sequencing state. Reset clears it at once, with no clock edge.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= StIdle;
      step_q   <= '0;
      phase_q  <= '0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
    end
  end

  // Next-state logic. Mode and go are only looked at in idle and on the last step.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    phase_d  = phase_q;
    done_d   = 1'b0;
    cycles_d = cycles_q;
    unique case (state_q)
      StIdle: begin
        if (!iHOLD && (!iMODE || iGO)) begin
          state_d = StRun;
          step_d  = FirstStep;
          phase_d = '0;
        end
      end
      StRun: begin
        if (!iHOLD) begin
          if (phase_q == LastPhase) begin
            done_d   = 1'b1;
            cycles_d = cycles_q + CYC_W'(1);
            if (!iMODE || iGO) begin
              step_d  = FirstStep;
              phase_d = '0;
            end else begin
              state_d = StIdle;
              step_d  = '0;
              phase_d = '0;
            end
          end else begin
            step_d  = step_q << 1;
            phase_d = phase_q + STEP_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        step_d  = '0;
        phase_d = '0;
      end
    endcase
  end

  // Outputs. All of them come from registered state only.
  always_comb begin
    oSTEP   = step_q;
    oPHASE  = phase_q;
    oDONE   = done_q;
    oCYCLES = cycles_q;
    oLAST   = step_q[NUM_STEPS-1];
    oBUSY   = (state_q == StRun);
  end

endmodule

// File: tb/tb_step_gen.sv
// Bench for step_gen. Three configurations (4/2/16, 2/1/16, 5/3/2) share the same inputs.
// Each one is checked every clock against a position-based reference model.
module tb_step_gen;

  logic clk = 1'b0;
  logic rst, mode, go, hold;

  always #5 clk = ~clk;

  logic [3:0]  step0;  logic [1:0] phase0; logic [15:0] cyc0; logic last0, done0, busy0;
  logic [1:0]  step1;  logic [0:0] phase1; logic [15:0] cyc1; logic last1, done1, busy1;
  logic [4:0]  step2;  logic [2:0] phase2; logic [1:0]  cyc2; logic last2, done2, busy2;

  step_gen #(.NUM_STEPS(4), .STEP_W(2), .CYC_W(16)) u_dut0 (
    .iCLK(clk), .iRST(rst), .iMODE(mode), .iGO(go), .iHOLD(hold),
    .oSTEP(step0), .oPHASE(phase0), .oLAST(last0), .oDONE(done0), .oBUSY(busy0), .oCYCLES(cyc0)
  );
  step_gen #(.NUM_STEPS(2), .STEP_W(1), .CYC_W(16)) u_dut1 (
    .iCLK(clk), .iRST(rst), .iMODE(mode), .iGO(go), .iHOLD(hold),
    .oSTEP(step1), .oPHASE(phase1), .oLAST(last1), .oDONE(done1), .oBUSY(busy1), .oCYCLES(cyc1)
  );
  step_gen #(.NUM_STEPS(5), .STEP_W(3), .CYC_W(2)) u_dut2 (
    .iCLK(clk), .iRST(rst), .iMODE(mode), .iGO(go), .iHOLD(hold),
    .oSTEP(step2), .oPHASE(phase2), .oLAST(last2), .oDONE(done2), .oBUSY(busy2), .oCYCLES(cyc2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: pos is the active step index, or -1 when idle.
  int pos [3];
  int cyc [3];
  bit done[3];

  function automatic int ns(input int i);
    case (i)
      0: return 4;
      1: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int cmod(input int i);
    return (i == 2) ? 4 : 65536;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i] = -1; cyc[i] = 0; done[i] = 1'b0;
    end
  endtask

  // Apply one clock edge to the model, using the inputs driven right now.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      done[i] = 1'b0;
      if (rst) begin
        pos[i] = -1; cyc[i] = 0;
      end else if (!hold) begin
        if (pos[i] < 0) begin
          if (!mode || go) pos[i] = 0;
        end else if (pos[i] == ns(i) - 1) begin
          done[i] = 1'b1;
          cyc[i]  = (cyc[i] + 1) % cmod(i);
          pos[i]  = (!mode || go) ? 0 : -1;
        end else begin
          pos[i] = pos[i] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] os, op, oc;
    logic        ol, od, ob;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin os = 32'(step0); op = 32'(phase0); oc = 32'(cyc0); ol = last0; od = done0; ob = busy0; end
        1: begin os = 32'(step1); op = 32'(phase1); oc = 32'(cyc1); ol = last1; od = done1; ob = busy1; end
        default: begin
          os = 32'(step2); op = 32'(phase2); oc = 32'(cyc2); ol = last2; od = done2; ob = busy2;
        end
      endcase
      check($sformatf("%s/%0d step", tag, i), os, (pos[i] < 0) ? 32'd0 : (32'd1 << pos[i]));
      check($sformatf("%s/%0d phase", tag, i), op, (pos[i] < 0) ? 32'd0 : 32'(pos[i]));
      check($sformatf("%s/%0d cycles", tag, i), oc, 32'(cyc[i]));
      check($sformatf("%s/%0d done", tag, i), 32'(od), 32'(done[i]));
      check($sformatf("%s/%0d last", tag, i), 32'(ol), 32'(pos[i] == ns(i) - 1));
      check($sformatf("%s/%0d busy", tag, i), 32'(ob), 32'(pos[i] >= 0));
      check($sformatf("%s/%0d onehot", tag, i), 32'($countones(os)), 32'(pos[i] >= 0));
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Called at edge+1: assert reset between edges and confirm it clears the outputs before the next edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    tick("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; go = 1'b0; hold = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    tick("reset_edge");

    // Free-run from reset release: after the start edge plus 12 clocks, three cycles are complete.
    rst = 1'b0;
    for (int k = 0; k < 13; k++) tick("freerun");
    check("cyc_after_12", 32'(cyc0), 32'd3);
    tick("freerun");

    // Reset with step 0010 active on the 4-step instance.
    async_reset();
    tick("restart");
    tick("to_0010");
    check("at_0010", 32'(step0), 32'b0010);
    async_reset();
    check("abort_cycles", 32'(cyc0), 32'd0);

    // Single cycle: a one-clock go pulse, then idle.
    mode = 1'b1; go = 1'b1;
    tick("single_go");
    go = 1'b0;
    for (int k = 0; k < 7; k++) tick("single");
    check("single_cycles", 32'(cyc0), 32'd1);

    // Back-to-back cycles while go stays high.
    go = 1'b1;
    for (int k = 0; k < 10; k++) tick("b2b");

    // Hold for 3 clocks on step 0100, then hold on 1000.
    go = 1'b0; mode = 1'b0;
    while (step0 != 4'b0100) tick("seek");
    hold = 1'b1;
    for (int k = 0; k < 3; k++) tick("hold_0100");
    hold = 1'b0;
    tick("rel_0100");
    check("after_hold", 32'(step0), 32'b1000);
    hold = 1'b1;
    for (int k = 0; k < 2; k++) tick("hold_1000");
    hold = 1'b0;
    tick("rel_1000");

    // Idle with hold high must not start, even with go high.
    async_reset();
    mode = 1'b1; go = 1'b1; hold = 1'b1;
    for (int k = 0; k < 3; k++) tick("idle_hold");
    hold = 1'b0;
    tick("idle_rel");

    // Random stimulus, with an occasional asynchronous reset.
    for (int k = 0; k < 600; k++) begin
      hold = ($urandom_range(0, 3) == 0);
      go   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 60) == 0) async_reset();
      else tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
